// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core pipeline control blocks.
//   hz_state_e     : hazard sequencer states (RUN / MD_WAIT / MEM_WAIT)
//   REG_ZERO       : architectural x0; writes to it never create a hazard
//   MD_TIMEOUT_DEF : default cycle limit for a mul/div wait
package core_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MD_WAIT  = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MD_TIMEOUT_DEF = 64;

endpackage

// File: rtl/hazard_controller_if.sv
// Bundle between the pipeline and the hazard controller.
//   pipeline -> controller : ID operand info, EX destination/load/mul-div/branch
//                            status, data-memory busy
//   controller -> pipeline : stall/bubble/flush controls, md_error, state_o
//   HAZARD_PERF_CNT_EN     : adds perf_stall_cycles / perf_flush_count
// modport master : pipeline side (drives status, receives controls)
// modport slave  : controller side
interface hazard_controller_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_md_start;
  logic        md_done;
  logic        ex_branch_taken;
  logic        dmem_busy;

  logic        pc_stall;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_stall;
  logic        id_ex_bubble;
  logic        ex_mem_stall;
  logic        ex_mem_bubble;
  logic        mem_wb_stall;
  logic        md_error;
  logic [1:0]  state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;
`endif

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_md_start, md_done, ex_branch_taken, dmem_busy,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
           ex_mem_stall, ex_mem_bubble, mem_wb_stall, md_error, state_o
`ifdef HAZARD_PERF_CNT_EN
         , perf_stall_cycles, perf_flush_count
`endif
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_md_start, md_done, ex_branch_taken, dmem_busy,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
           ex_mem_stall, ex_mem_bubble, mem_wb_stall, md_error, state_o
`ifdef HAZARD_PERF_CNT_EN
         , perf_stall_cycles, perf_flush_count
`endif
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use match: the instruction in EX is a load whose
// destination (other than x0) is a source operand read by the instruction in ID.
//   in  : id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read
//   out : hazard
module load_use_detect
  import core_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       hazard
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
    hazard  = ex_mem_read && (ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the 5-stage RV32 core. Resolves the
// hazards forwarding cannot: load-use, mul/div occupancy of EX, data-memory
// wait states and taken-branch flushes.
//   clk, rst : core clock, synchronous active-high reset
//   hz       : hazard_controller_if.slave (status in, pipeline controls out)
// Parameters: MD_TIMEOUT (max MD_WAIT cycles), CNT_W (wait counter width).
// Optional: HAZARD_PERF_CNT_EN adds stall-cycle and flush counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; arbitrates dmem > mul/div > branch > load-use
// MD_WAIT  | mul/div occupies EX; front held, NOPs into EX/MEM
// MEM_WAIT | data memory busy; whole pipe frozen
module hazard_controller
  import core_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
  parameter int CNT_W      = 7
) (
  input  logic          clk,
  input  logic          rst,
  hazard_controller_if.slave hz
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(MD_TIMEOUT);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             md_error_q, md_error_d;

  logic load_use;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble;
  logic ex_mem_stall, ex_mem_bubble, mem_wb_stall;

  load_use_detect u_load_use_detect (
    .id_rs1      (hz.id_rs1),
    .id_rs2      (hz.id_rs2),
    .id_uses_rs1 (hz.id_uses_rs1),
    .id_uses_rs2 (hz.id_uses_rs2),
    .ex_rd       (hz.ex_rd),
    .ex_mem_read (hz.ex_mem_read),
    .hazard      (load_use)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    md_error_d    = 1'b0;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_stall  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_stall  = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (hz.dmem_busy) begin
          // A mul/div start in the same cycle stays parked in EX and
          // reasserts once memory releases.
          {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall} = '1;
          state_d = ST_MEM_WAIT;
        end else if (hz.ex_md_start) begin
          if (!hz.md_done) begin
            {pc_stall, if_id_stall, id_ex_stall, ex_mem_bubble} = '1;
            cnt_d   = CNT_W'(1);
            state_d = ST_MD_WAIT;
          end
        end else if (hz.ex_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use) begin
          // One bubble clears the match, so no state is needed.
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
        end
      end

      ST_MD_WAIT: begin
        if (hz.dmem_busy) begin
          // EX/MEM still holds a live memory op: hold it rather than bubble.
          {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall} = '1;
          if (cnt_q != TMO) cnt_d = cnt_q + CNT_W'(1);
        end else if (hz.md_done) begin
          state_d = ST_RUN;
        end else if (cnt_q == TMO) begin
          md_error_d = 1'b1;
          state_d    = ST_RUN;
        end else begin
          {pc_stall, if_id_stall, id_ex_stall, ex_mem_bubble} = '1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_MEM_WAIT: begin
        if (hz.dmem_busy) begin
          {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall} = '1;
        end else begin
          state_d = ST_RUN;
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      md_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      md_error_q <= md_error_d;
    end
  end

  assign hz.pc_stall      = pc_stall      & ~rst;
  assign hz.if_id_stall   = if_id_stall   & ~rst;
  assign hz.if_id_flush   = if_id_flush   & ~rst;
  assign hz.id_ex_stall   = id_ex_stall   & ~rst;
  assign hz.id_ex_bubble  = id_ex_bubble  & ~rst;
  assign hz.ex_mem_stall  = ex_mem_stall  & ~rst;
  assign hz.ex_mem_bubble = ex_mem_bubble & ~rst;
  assign hz.mem_wb_stall  = mem_wb_stall  & ~rst;
  assign hz.md_error      = md_error_q;
  assign hz.state_o       = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (hz.pc_stall)    perf_stall_d = perf_stall_q + 32'd1;
    if (hz.if_id_flush) perf_flush_d = perf_flush_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign hz.perf_stall_cycles = perf_stall_q;
  assign hz.perf_flush_count  = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed testbench for hazard_controller (MD_TIMEOUT overridden to 8).
module tb_hazard_controller;
  import core_ctrl_pkg::*;

  // Control vector order: pc_stall, if_id_stall, if_id_flush, id_ex_stall,
  // id_ex_bubble, ex_mem_stall, ex_mem_bubble, mem_wb_stall
  localparam logic [7:0] C_NONE   = 8'b0000_0000;
  localparam logic [7:0] C_FREEZE = 8'b1101_0101;
  localparam logic [7:0] C_MD     = 8'b1101_0010;
  localparam logic [7:0] C_LU     = 8'b1100_1000;
  localparam logic [7:0] C_BR     = 8'b0010_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  hazard_controller_if hz_if ();

  hazard_controller #(.MD_TIMEOUT(8), .CNT_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz_if.slave)
  );

  logic [7:0] ctl;
  assign ctl = {hz_if.pc_stall, hz_if.if_id_stall, hz_if.if_id_flush,
                hz_if.id_ex_stall, hz_if.id_ex_bubble, hz_if.ex_mem_stall,
                hz_if.ex_mem_bubble, hz_if.mem_wb_stall};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    hz_if.id_rs1 = 5'd0;  hz_if.id_rs2 = 5'd0;
    hz_if.id_uses_rs1 = 1'b0; hz_if.id_uses_rs2 = 1'b0;
    hz_if.ex_rd = 5'd0;   hz_if.ex_mem_read = 1'b0;
    hz_if.ex_md_start = 1'b0; hz_if.md_done = 1'b0;
    hz_if.ex_branch_taken = 1'b0; hz_if.dmem_busy = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    hz_if.ex_mem_read = 1'b1; hz_if.ex_rd = rd;
    hz_if.id_rs1 = rd; hz_if.id_uses_rs1 = 1'b1;
  endtask

  // Check this cycle's outputs mid-cycle, then advance to just after the next edge.
  task automatic expect_cyc(input string tag, input logic [7:0] exp_ctl,
                            input logic [1:0] exp_st, input logic exp_err);
    @(negedge clk);
    check({tag, ".ctl"}, 32'(ctl), 32'(exp_ctl));
    check({tag, ".st"},  32'(hz_if.state_o), 32'(exp_st));
    check({tag, ".err"}, 32'(hz_if.md_error), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  task automatic run_timeout(input string tag);
    set_idle(); hz_if.ex_md_start = 1'b1;
    expect_cyc({tag, "0"}, C_MD, 2'd0, 1'b0);
    hz_if.ex_md_start = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      set_idle();
      if (i == 3) begin
        hz_if.dmem_busy = 1'b1;
        expect_cyc({tag, "_busy"}, C_FREEZE, 2'd1, 1'b0);
      end else if (i == 5) begin
        hz_if.ex_branch_taken = 1'b1; set_lu(5'd9);
        expect_cyc({tag, "_ign"}, C_MD, 2'd1, 1'b0);
      end else begin
        expect_cyc({tag, "_w"}, C_MD, 2'd1, 1'b0);
      end
    end
    set_idle();
    expect_cyc({tag, "8"}, C_NONE, 2'd1, 1'b0);
    expect_cyc({tag, "9"}, C_NONE, 2'd0, 1'b1);
    expect_cyc({tag, "10"}, C_NONE, 2'd0, 1'b0);
  endtask

  initial begin
    set_idle();
    @(posedge clk); #1;
    // Reset with an active load-use match: outputs must stay low
    set_lu(5'd5);
    expect_cyc("rst_a", C_NONE, 2'd0, 1'b0);
    expect_cyc("rst_b", C_NONE, 2'd0, 1'b0);
    rst = 1'b0;

    // Load-use variants
    expect_cyc("lu_rs1", C_LU, 2'd0, 1'b0);
    set_idle(); set_lu(5'd0);
    expect_cyc("lu_x0", C_NONE, 2'd0, 1'b0);
    set_idle(); hz_if.ex_mem_read = 1'b1; hz_if.ex_rd = 5'd12;
    hz_if.id_rs2 = 5'd12; hz_if.id_uses_rs2 = 1'b1;
    expect_cyc("lu_rs2", C_LU, 2'd0, 1'b0);
    hz_if.id_uses_rs2 = 1'b0;
    expect_cyc("lu_nouse", C_NONE, 2'd0, 1'b0);
    set_idle(); set_lu(5'd5); hz_if.ex_mem_read = 1'b0;
    expect_cyc("lu_noload", C_NONE, 2'd0, 1'b0);

    // Mul/div with md_done at +4
    set_idle(); hz_if.ex_md_start = 1'b1;
    expect_cyc("md0", C_MD, 2'd0, 1'b0);
    hz_if.ex_md_start = 1'b0;
    for (int i = 1; i <= 3; i++) expect_cyc("md_w", C_MD, 2'd1, 1'b0);
    hz_if.md_done = 1'b1;
    expect_cyc("md_done", C_NONE, 2'd1, 1'b0);
    set_idle();
    expect_cyc("md_after", C_NONE, 2'd0, 1'b0);

    // Single-cycle mul/div
    hz_if.ex_md_start = 1'b1; hz_if.md_done = 1'b1;
    expect_cyc("md_1c", C_NONE, 2'd0, 1'b0);
    set_idle();
    expect_cyc("md_1c_nx", C_NONE, 2'd0, 1'b0);

    // Timeout, with memory busy and ignored events inside the wait
    run_timeout("tmo");

    // dmem_busy beats branch and load-use; branch beats load-use on release
    set_idle(); hz_if.dmem_busy = 1'b1; hz_if.ex_branch_taken = 1'b1; set_lu(5'd7);
    expect_cyc("pri0", C_FREEZE, 2'd0, 1'b0);
    expect_cyc("pri1", C_FREEZE, 2'd2, 1'b0);
    expect_cyc("pri2", C_FREEZE, 2'd2, 1'b0);
    hz_if.dmem_busy = 1'b0;
    expect_cyc("pri_rel", C_NONE, 2'd2, 1'b0);
    expect_cyc("pri_br", C_BR, 2'd0, 1'b0);
    set_idle();
    expect_cyc("pri_idle", C_NONE, 2'd0, 1'b0);

    // Branch over load-use straight from RUN
    hz_if.ex_branch_taken = 1'b1; set_lu(5'd3);
    expect_cyc("br_lu", C_BR, 2'd0, 1'b0);

    // dmem_busy defers a mul/div start
    set_idle(); hz_if.dmem_busy = 1'b1; hz_if.ex_md_start = 1'b1;
    expect_cyc("bmd0", C_FREEZE, 2'd0, 1'b0);
    hz_if.dmem_busy = 1'b0;
    expect_cyc("bmd_rel", C_NONE, 2'd2, 1'b0);
    expect_cyc("bmd_start", C_MD, 2'd0, 1'b0);
    hz_if.ex_md_start = 1'b0; hz_if.md_done = 1'b1;
    expect_cyc("bmd_done", C_NONE, 2'd1, 1'b0);
    set_idle();
    expect_cyc("bmd_idle", C_NONE, 2'd0, 1'b0);

    // Reset in MD_WAIT at counter=3
    hz_if.ex_md_start = 1'b1;
    expect_cyc("rmd0", C_MD, 2'd0, 1'b0);
    hz_if.ex_md_start = 1'b0;
    expect_cyc("rmd1", C_MD, 2'd1, 1'b0);
    expect_cyc("rmd2", C_MD, 2'd1, 1'b0);
    rst = 1'b1;
    expect_cyc("rmd_rst", C_NONE, 2'd1, 1'b0);
    rst = 1'b0;
    expect_cyc("rmd_post", C_NONE, 2'd0, 1'b0);
    run_timeout("rtmo");

`ifdef HAZARD_PERF_CNT_EN
    rst = 1'b1; set_idle();
    expect_cyc("pf_rst", C_NONE, 2'd0, 1'b0);
    rst = 1'b0; set_lu(5'd4);
    expect_cyc("pf_lu", C_LU, 2'd0, 1'b0);
    set_idle(); hz_if.ex_branch_taken = 1'b1;
    expect_cyc("pf_br", C_BR, 2'd0, 1'b0);
    set_idle();
    @(negedge clk);
    check("perf_stall", hz_if.perf_stall_cycles, 32'd1);
    check("perf_flush", hz_if.perf_flush_count, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
